// File: rtl/tensor_xfer_if.sv
// tensor_xfer_if: DMA-side transfer bundle between the DMA controller and the
// tensor unit's transfer port.
//   set          DMA target select (0=A, 1=B, 2=X pop, 3=reserved)
//   depth_in     column dimension of the matrix being moved
//   width_in     row dimension of the matrix being moved
//   busy_in      transfer in progress (rising edge starts a transfer)
//   finished_in  end-of-transfer pulse
//   tensor_wen   write strobe, memory -> operand buffer
//   tensor_ren   read strobe, X FIFO -> memory
//   wr_data      word written on tensor_wen
//   rd_data      popped X word (registered)
//   rd_valid     rd_data valid this cycle
// Modports: master = DMA controller, slave = tensor unit.
interface tensor_xfer_if #(
  parameter int DATAWIDTH = 8
);
  logic [1:0]           set;
  logic [DATAWIDTH-1:0] depth_in;
  logic [DATAWIDTH-1:0] width_in;
  logic                 busy_in;
  logic                 finished_in;
  logic                 tensor_wen;
  logic                 tensor_ren;
  logic [DATAWIDTH-1:0] wr_data;
  logic [DATAWIDTH-1:0] rd_data;
  logic                 rd_valid;

  modport master (
    output set, depth_in, width_in, busy_in, finished_in,
    output tensor_wen, tensor_ren, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  set, depth_in, width_in, busy_in, finished_in,
    input  tensor_wen, tensor_ren, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/tensor_xfer_port.sv
// tensor_xfer_port: tensor-unit responder for DMA transfers. Sinks DMA words
// into operand buffers A and B, sources result words from the X FIFO, and
// reports captured matrix dimensions and load status to the compute core.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   dma                 DMA transfer bundle (slave side)
//   x_push, x_data      compute core pushes a result word into X
//   x_full, x_empty     X FIFO status (from registers)
//   x_count             X FIFO occupancy
//   a_raddr, b_raddr    compute-side read addresses
//   a_rdata, b_rdata    buffer read data, one cycle after the address
//   a_loaded, b_loaded  buffer holds a complete matrix
//   dim_rows, dim_cols  dimensions captured at the last completed load
//   err                 sticky error: overflow, underflow, short/bad load
module tensor_xfer_port #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  tensor_xfer_if.slave         dma,
  input  logic                 x_push,
  input  logic [DATAWIDTH-1:0] x_data,
  output logic                 x_full,
  output logic                 x_empty,
  output logic [AW:0]          x_count,
  input  logic [AW-1:0]        a_raddr,
  input  logic [AW-1:0]        b_raddr,
  output logic [DATAWIDTH-1:0] a_rdata,
  output logic [DATAWIDTH-1:0] b_rdata,
  output logic                 a_loaded,
  output logic                 b_loaded,
  output logic [DATAWIDTH-1:0] dim_rows,
  output logic [DATAWIDTH-1:0] dim_cols,
  output logic                 err
);

  localparam int EW = 2 * DATAWIDTH;
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);
  localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, PRIME, DRAIN, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 busy_prev_reg;
  logic [EW-1:0]        exp_reg;
  logic [DATAWIDTH-1:0] depth_reg, width_reg;
  logic [AW:0]          wptr_reg;
  logic [1:0]           loaded_reg;   // bit 0 = A, bit 1 = B
  logic [DATAWIDTH-1:0] dim_rows_reg, dim_cols_reg;
  logic                 err_reg;

  logic [AW-1:0]        x_wptr_reg, x_rptr_reg;
  logic [AW:0]          x_count_reg;
  logic [DATAWIDTH-1:0] x_mem [DEPTH];
  logic [DATAWIDTH-1:0] rd_data_reg;
  logic                 rd_valid_reg;

  logic          busy_rise, busy_fall;
  logic          in_load, load_sel, in_x;
  logic          wr_accept, wr_drop;
  logic          load_end, load_ok;
  logic          start_load, exp_bad, bad_set;
  logic [EW-1:0] exp_new;
  logic          pop, pop_ok, underflow, push_ok, push_drop;

  assign busy_rise = dma.busy_in & ~busy_prev_reg;
  assign busy_fall = ~dma.busy_in & busy_prev_reg;

  assign in_load  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign load_sel = (state_reg == LOAD_B);
  assign in_x     = (state_reg == PRIME) || (state_reg == DRAIN);

  // wptr saturates at DEPTH; further strobes are dropped as overflow.
  assign wr_accept = in_load & dma.tensor_wen & (wptr_reg < DEPTH_P);
  assign wr_drop   = in_load & dma.tensor_wen & ~(wptr_reg < DEPTH_P);

  // A load completes on finished_in, or on busy falling without it.
  assign load_end = in_load & (dma.finished_in | busy_fall);
  assign load_ok  = (EW'(wptr_reg) == exp_reg);

  assign exp_new    = EW'(dma.depth_in) * EW'(dma.width_in);
  assign exp_bad    = (exp_new == '0) || (exp_new > DEPTH_E);
  assign start_load = (state_reg == IDLE) & busy_rise & ~dma.set[1] & ~dma.finished_in;
  assign bad_set    = (state_reg == IDLE) & busy_rise & (dma.set == 2'd3);

  assign pop       = in_x & dma.tensor_ren;
  assign pop_ok    = pop & ~x_empty;
  assign underflow = pop & x_empty;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_ok   = x_push & (~x_full | pop_ok);
  assign push_drop = x_push & ~push_ok;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (busy_rise) begin
          case (dma.set)
            2'd0:    state_next = LOAD_A;
            2'd1:    state_next = LOAD_B;
            2'd2:    state_next = PRIME;
            default: state_next = IDLE;
          endcase
        end
      end
      LOAD_A, LOAD_B, DRAIN: begin
        if (busy_fall) state_next = IDLE;
      end
      PRIME: begin
        if (busy_fall) state_next = IDLE;
        else if (dma.tensor_ren) state_next = DRAIN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (dma.finished_in && (state_reg != DONE)) state_next = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_prev_reg <= 1'b0;
      exp_reg       <= '0;
      depth_reg     <= '0;
      width_reg     <= '0;
      wptr_reg      <= '0;
      loaded_reg    <= '0;
      dim_rows_reg  <= '0;
      dim_cols_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      busy_prev_reg <= dma.busy_in;
      if (start_load) begin
        exp_reg               <= exp_new;
        depth_reg             <= dma.depth_in;
        width_reg             <= dma.width_in;
        wptr_reg              <= '0;
        loaded_reg[dma.set[0]] <= 1'b0;
      end else if (wr_accept) begin
        wptr_reg <= wptr_reg + (AW + 1)'(1);
      end
      if (load_end && load_ok) begin
        loaded_reg[load_sel] <= 1'b1;
        dim_rows_reg         <= width_reg;
        dim_cols_reg         <= depth_reg;
      end
      if (bad_set || (start_load && exp_bad) || wr_drop ||
          (load_end && !load_ok) || underflow || push_drop)
        err_reg <= 1'b1;
    end
  end

  // Operand buffers A (index 0) and B (index 1): write port from the DMA,
  // always-enabled registered read port for the compute core.
  logic [AW-1:0]        op_raddr [2];
  logic [DATAWIDTH-1:0] op_rdata [2];

  assign op_raddr[0] = a_raddr;
  assign op_raddr[1] = b_raddr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op_buf
      logic [DATAWIDTH-1:0] mem [DEPTH];
      logic [DATAWIDTH-1:0] rdata_reg;
      logic                 we;

      assign we = wr_accept && (load_sel == gi[0]);

      always_ff @(posedge clk) begin
        if (we) mem[wptr_reg[AW-1:0]] <= dma.wr_data;
      end

      always_ff @(posedge clk) begin
        if (rst) rdata_reg <= '0;
        else     rdata_reg <= mem[op_raddr[gi]];
      end

      assign op_rdata[gi] = rdata_reg;
    end
  endgenerate

  // X FIFO storage (contents not reset).
  always_ff @(posedge clk) begin
    if (push_ok) x_mem[x_wptr_reg] <= x_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_wptr_reg   <= '0;
      x_rptr_reg   <= '0;
      x_count_reg  <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (push_ok) x_wptr_reg <= x_wptr_reg + AW'(1);
      if (pop_ok)  x_rptr_reg <= x_rptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   x_count_reg <= x_count_reg + (AW + 1)'(1);
        2'b01:   x_count_reg <= x_count_reg - (AW + 1)'(1);
        default: x_count_reg <= x_count_reg;
      endcase
      rd_valid_reg <= pop;
      // An underflowing pop still returns a valid beat, carrying zero.
      if (pop) rd_data_reg <= pop_ok ? x_mem[x_rptr_reg] : '0;
    end
  end

  assign x_count      = x_count_reg;
  assign x_full       = (x_count_reg == DEPTH_P);
  assign x_empty      = (x_count_reg == '0);
  assign dma.rd_data  = rd_data_reg;
  assign dma.rd_valid = rd_valid_reg;
  assign a_rdata      = op_rdata[0];
  assign b_rdata      = op_rdata[1];
  assign a_loaded     = loaded_reg[0];
  assign b_loaded     = loaded_reg[1];
  assign dim_rows     = dim_rows_reg;
  assign dim_cols     = dim_cols_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_tensor_xfer_port.sv
// tb_tensor_xfer_port: directed, self-checking bench for tensor_xfer_port.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_tensor_xfer_port;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          x_push;
  logic [DW-1:0] x_data;
  logic          x_full, x_empty;
  logic [AW:0]   x_count;
  logic [AW-1:0] a_raddr, b_raddr;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_loaded, b_loaded;
  logic [DW-1:0] dim_rows, dim_cols;
  logic          err;

  int total = 0;
  int bad = 0;

  tensor_xfer_if #(.DATAWIDTH(DW)) dma ();

  tensor_xfer_port #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .dma      (dma),
    .x_push   (x_push),
    .x_data   (x_data),
    .x_full   (x_full),
    .x_empty  (x_empty),
    .x_count  (x_count),
    .a_raddr  (a_raddr),
    .b_raddr  (b_raddr),
    .a_rdata  (a_rdata),
    .b_rdata  (b_rdata),
    .a_loaded (a_loaded),
    .b_loaded (b_loaded),
    .dim_rows (dim_rows),
    .dim_cols (dim_cols),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_data;
  } rd_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    dma.set = 2'd0; dma.depth_in = '0; dma.width_in = '0;
    dma.busy_in = 1'b0; dma.finished_in = 1'b0;
    dma.tensor_wen = 1'b0; dma.tensor_ren = 1'b0; dma.wr_data = '0;
    x_push = 1'b0; x_data = '0; a_raddr = '0; b_raddr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic dma_start(input logic [1:0] s, input logic [DW-1:0] d, input logic [DW-1:0] w);
    dma.set = s; dma.depth_in = d; dma.width_in = w; dma.busy_in = 1'b1;
    tick();
  endtask

  task automatic dma_finish();
    dma.finished_in = 1'b1;
    tick();
    dma.finished_in = 1'b0;
    dma.busy_in = 1'b0;
    tick();
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      dma.tensor_wen = 1'b1;
      dma.wr_data = base + DW'(i);
      tick();
    end
    dma.tensor_wen = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    x_push = 1'b1;
    x_data = d;
    tick();
    x_push = 1'b0;
  endtask

  rd_vec_t a_vec [6];

  initial begin
    a_vec[0] = '{addr: 4'd5, exp_data: 8'h15};
    a_vec[1] = '{addr: 4'd0, exp_data: 8'h10};
    a_vec[2] = '{addr: 4'd3, exp_data: 8'h13};
    a_vec[3] = '{addr: 4'd1, exp_data: 8'h11};
    a_vec[4] = '{addr: 4'd4, exp_data: 8'h14};
    a_vec[5] = '{addr: 4'd2, exp_data: 8'h12};

    // Reset state
    apply_reset();
    check("reset x_empty", 32'(x_empty), 1);
    check("reset x_full", 32'(x_full), 0);
    check("reset x_count", 32'(x_count), 0);
    check("reset a_loaded", 32'(a_loaded), 0);
    check("reset rd_valid", 32'(dma.rd_valid), 0);
    check("reset rd_data", 32'(dma.rd_data), 0);
    check("reset dim_rows", 32'(dim_rows), 0);
    check("reset err", 32'(err), 0);
    $display("reset done");

    // Load A: depth 2, width 3, six words
    dma_start(2'd0, 8'd2, 8'd3);
    write_words(8'h10, 6);
    dma_finish();
    check("loadA a_loaded", 32'(a_loaded), 1);
    check("loadA b_loaded", 32'(b_loaded), 0);
    check("loadA dim_rows", 32'(dim_rows), 3);
    check("loadA dim_cols", 32'(dim_cols), 2);
    check("loadA err", 32'(err), 0);
    $display("load A 2x3 complete");
    for (int i = 0; i < 6; i++) begin
      a_raddr = a_vec[i].addr;
      tick();
      check($sformatf("a_rdata[%0d]", a_vec[i].addr), 32'(a_rdata), 32'(a_vec[i].exp_data));
      $display("read A addr %0d", a_vec[i].addr);
    end

    // Short load B: expects 4 words, gets 3
    dma_start(2'd1, 8'd2, 8'd2);
    write_words(8'h20, 3);
    dma_finish();
    b_raddr = 4'd2;
    tick();
    check("shortB b_loaded", 32'(b_loaded), 0);
    check("shortB err", 32'(err), 1);
    check("shortB a_loaded kept", 32'(a_loaded), 1);
    check("shortB dim_rows kept", 32'(dim_rows), 3);
    check("shortB b_rdata[2]", 32'(b_rdata), 32'h22);
    $display("short load B complete");

    // Drain X: three results, PRIME for two idle cycles, then three pops
    apply_reset();
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    check("drain x_count", 32'(x_count), 3);
    dma_start(2'd2, 8'd1, 8'd3);
    tick();
    tick();
    check("drain prime rd_valid", 32'(dma.rd_valid), 0);
    for (int i = 0; i < 3; i++) begin
      dma.tensor_ren = 1'b1;
      tick();
      check($sformatf("drain rd_valid %0d", i), 32'(dma.rd_valid), 1);
      check($sformatf("drain rd_data %0d", i), 32'(dma.rd_data), 32'hA1 + i);
      $display("pop %0d", i);
    end
    dma.tensor_ren = 1'b0;
    tick();
    check("drain rd_valid pulse", 32'(dma.rd_valid), 0);
    check("drain x_empty", 32'(x_empty), 1);
    dma_finish();
    check("drain err", 32'(err), 0);

    // Underflow: one entry, two pops
    apply_reset();
    push_word(8'h55);
    dma_start(2'd2, 8'd1, 8'd2);
    dma.tensor_ren = 1'b1;
    tick();
    check("uflow first rd_data", 32'(dma.rd_data), 32'h55);
    check("uflow first err", 32'(err), 0);
    tick();
    check("uflow second rd_data", 32'(dma.rd_data), 0);
    check("uflow second rd_valid", 32'(dma.rd_valid), 1);
    check("uflow err", 32'(err), 1);
    dma.tensor_ren = 1'b0;
    dma_finish();
    $display("underflow transaction complete");

    // FIFO full / wrap
    apply_reset();
    for (int i = 0; i < DEPTH; i++) push_word(8'h30 + DW'(i));
    check("full x_full", 32'(x_full), 1);
    check("full err before overflow", 32'(err), 0);
    push_word(8'h40);
    check("ovfl x_count", 32'(x_count), 16);
    check("ovfl err", 32'(err), 1);
    dma_start(2'd2, 8'd4, 8'd4);
    x_push = 1'b1;
    x_data = 8'h77;
    dma.tensor_ren = 1'b1;
    tick();
    x_push = 1'b0;
    check("pushpop rd_data", 32'(dma.rd_data), 32'h30);
    check("pushpop x_count", 32'(x_count), 16);
    check("pushpop x_full", 32'(x_full), 1);
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      check($sformatf("wrap rd_data %0d", i), 32'(dma.rd_data), 32'h30 + i);
    end
    tick();
    check("wrap last rd_data", 32'(dma.rd_data), 32'h77);
    dma.tensor_ren = 1'b0;
    check("wrap x_empty", 32'(x_empty), 1);
    dma_finish();
    $display("fifo wrap transaction complete");

    // Reset mid-load of A, then a fresh 1x1 load
    apply_reset();
    dma_start(2'd0, 8'd2, 8'd2);
    write_words(8'h50, 3);
    rst = 1'b1;
    dma.busy_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("midrst a_loaded", 32'(a_loaded), 0);
    check("midrst err", 32'(err), 0);
    dma_start(2'd0, 8'd1, 8'd1);
    write_words(8'h99, 1);
    dma_finish();
    a_raddr = 4'd0;
    tick();
    check("fresh a_loaded", 32'(a_loaded), 1);
    check("fresh dim_rows", 32'(dim_rows), 1);
    check("fresh dim_cols", 32'(dim_cols), 1);
    check("fresh err", 32'(err), 0);
    check("fresh a_rdata", 32'(a_rdata), 32'h99);
    $display("reset mid-load and 1x1 load complete");

    // Reserved target and oversized load both flag err
    apply_reset();
    dma_start(2'd3, 8'd1, 8'd1);
    check("set3 err", 32'(err), 1);
    dma.busy_in = 1'b0;
    tick();
    apply_reset();
    dma_start(2'd1, 8'd5, 8'd4);
    check("oversize err", 32'(err), 1);
    check("oversize b_loaded", 32'(b_loaded), 0);
    dma_finish();
    $display("error target transactions complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tensor_xfer_port.md
# tensor_xfer_port

Tensor-unit side of the DMA transfer interface: the responder that DMA `tensor_wen`/`tensor_ren` strobes act on. It sinks memory words into on-chip operand buffers A and B and sources result words from an X FIFO back toward memory. It also exposes captured matrix dimensions and load status to the compute engine. It sits between the DMA controller and the systolic/compute core.

## Interface
- `DATAWIDTH`, 8, word and dimension width
- `DEPTH`, 16, entries per buffer (A, B, X); power of two
- `AW`, $clog2(DEPTH), buffer pointer width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `set`  in  2  DMA target: 0=A, 1=B, 2=X (pop), 3=reserved
- `depth_in`  in  DATAWIDTH  DMA column dimension
- `width_in`  in  DATAWIDTH  DMA row dimension
- `busy_in`  in  1  DMA transfer in progress
- `finished_in`  in  1  DMA end-of-transfer pulse
- `tensor_wen`  in  1  write strobe, memory→buffer
- `tensor_ren`  in  1  read strobe, X→memory
- `wr_data`  in  DATAWIDTH  word sampled on `tensor_wen`
- `rd_data`  out  DATAWIDTH  popped X word (registered)
- `rd_valid`  out  1  `rd_data` valid this cycle
- `x_push`  in  1  compute core pushes result
- `x_data`  in  DATAWIDTH  result word
- `x_full`, `x_empty`  out  1  X FIFO status
- `x_count`  out  AW+1  X occupancy
- `a_raddr`, `b_raddr`  in  AW  compute-side read addresses
- `a_rdata`, `b_rdata`  out  DATAWIDTH  buffer data, 1-cycle latency
- `a_loaded`, `b_loaded`  out  1  buffer holds a complete matrix
- `dim_rows`, `dim_cols`  out  DATAWIDTH  dimensions captured at last completed load
- `err`  out  1  sticky: overflow, underflow, or short load

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, PRIME, DRAIN, DONE.
- IDLE → LOAD_A / LOAD_B / PRIME on the rising edge of `busy_in`, selected by `set` = 0 / 1 / 2. `set`=3 stays IDLE and sets `err`.
- Load entry:
  - latch `exp = depth_in*width_in`, 2·DATAWIDTH bits.
  - `exp > DEPTH` or `exp == 0` sets `err`.
  - Clear the target `*_loaded` and the write pointer.
- LOAD_x: each cycle `tensor_wen`=1, write `wr_data` to buf[wptr] and increment wptr.
  - Writes beyond DEPTH are dropped and set `err`.
  - `tensor_ren` in a load state is ignored.
- PRIME: absorbs the DMA's 2-cycle FIFO delay. Go to DRAIN on the first cycle `tensor_ren`=1.
- PRIME/DRAIN: each cycle `tensor_ren`=1, pop X. Popping empty gives `rd_data`=0, `rd_valid`=1, and sets `err`.
- Any state with `finished_in`=1 → DONE.
  - In LOAD_x: if wptr == `exp`, set `x_loaded`=1 and update `dim_rows`/`dim_cols`. Otherwise set `err` and leave `x_loaded`=0.
- DONE → IDLE after 1 cycle.
- A `busy_in` fall without `finished_in` → IDLE, same completion check as DONE.
- X FIFO:
  - push from `x_push` when not full; push on full is dropped and sets `err`.
  - Simultaneous push and pop on the same cycle (nonempty, or full): both occur and count is unchanged.
  - Pointers wrap modulo DEPTH.
- Compute reads of A/B are always enabled. They return the stored value even while a load is in progress.
- `err` clears only on reset.

## Timing
- Reset values:
  - all outputs 0, except `x_empty`=1.
  - FSM=IDLE; pointers, counts and flags 0.
  - Buffer contents not reset.
- `tensor_wen` sample to data readable on `a_rdata`/`b_rdata`: 2 cycles (write edge, then read-register edge).
- `tensor_ren` at edge N → `rd_data`/`rd_valid` updated at edge N+1. `rd_valid` is a single-cycle pulse per pop.
- `busy_in` rise at edge N → state change at edge N+1. The first `tensor_wen` is accepted from edge N+1.
- `x_full`, `x_empty`, `x_count` reflect post-edge state, combinational from registers.
- Reset mid-transfer: FSM returns to IDLE next edge; `*_loaded` and `err` cleared.

## Test plan
- Load A: `set`=0, depth=2, width=3, six `tensor_wen` with 0x10..0x15, then `finished_in` → `a_loaded`=1, `dim_rows`=3, `dim_cols`=2; `a_raddr`=5 gives 0x15 one cycle later; `err`=0.
- Short load B: depth=2, width=2, three writes, then `finished_in` → `b_loaded`=0, `err`=1.
- Drain X: push 0xA1, 0xA2, 0xA3; `set`=2 with busy; two idle cycles, then 3 `tensor_ren` → `rd_data` 0xA1, 0xA2, 0xA3, each with `rd_valid`; `x_empty`=1.
- Underflow: 1 entry in X, two pops → second `rd_data`=0, `err`=1.
- FIFO full/wrap: push DEPTH+1 words → `x_full`=1, `x_count`=16, `err`=1. Simultaneous push and pop at full keeps `x_count`=16 with pointers wrapping. Drain returns the first 16 words in order.
- Reset mid-load of A after 3 writes → IDLE, `a_loaded`=0. A fresh 1×1 load then completes with `a_loaded`=1.
